command_credit_tracker: RTL and testbench
=========================================

COMMAND_CREDIT_TRACKER -- requirements
Module: command_credit_tracker

Interface
REQ-001 SHALL have parameter TAG_WIDTH, default 8, width of the PSL command tag.
REQ-002 SHALL have parameter CREDIT_WIDTH, default 8, width of the credit counter and room value.
REQ-003 SHALL have the port list below, clock and reset first. One clock; reset is asynchronous and active-high.
- clock  input  1  block clock; all state updates on the rising edge.
- reset_in  input  1  asynchronous active-high reset.
- enabled_in  input  1  job running; a 0->1 edge starts a session.
- room_in  input  CREDIT_WIDTH  PSL command room; sampled at session start.
- cmd_valid_in  input  1  upstream command request.
- cmd_tag_in  input  TAG_WIDTH  tag of the upstream command.
- cmd_ready_out  output  1  accept indication for the upstream command.
- cmd_valid_out  output  1  registered command valid toward the PSL.
- cmd_tag_out  output  TAG_WIDTH  registered command tag toward the PSL.
- rsp_valid_in  input  1  PSL response valid.
- rsp_tag_in  input  TAG_WIDTH  tag carried by the response.
- rsp_credits_in  input  9  signed credit return carried by the response.
- credits_out  output  CREDIT_WIDTH  current credit count.
- outstanding_out  output  TAG_WIDTH+1  number of in-flight tags.
- idle_out  output  1  high when state is DISABLED.
- credit_overflow_error_out  output  1  sticky credit overflow flag.
- tag_error_out  output  2  sticky flags: bit0 unknown response tag, bit1 duplicate issue attempt.

Function
REQ-004 SHALL implement an FSM with states DISABLED, ACTIVE and DRAINING.
REQ-005 In DISABLED, on enabled_in 0->1, SHALL load credits from room_in and clear the outstanding bitmap, then enter ACTIVE.
REQ-006 In ACTIVE, when enabled_in=0, SHALL enter DRAINING.
REQ-007 In DRAINING, when outstanding=0, SHALL enter DISABLED.
REQ-008 SHALL drive cmd_ready_out combinationally as: state==ACTIVE, credits>0, bitmap[cmd_tag_in]==0.
REQ-009 A command is accepted when cmd_valid_in and cmd_ready_out are both high; on accept, cmd_valid_out=1 and cmd_tag_out=cmd_tag_in in the next cycle (latency 1).
REQ-010 When no command is accepted, cmd_valid_out SHALL be 0 in the next cycle.
REQ-011 On accept, SHALL set bitmap[tag] and decrement credits by 1.
REQ-012 On rsp_valid_in with bitmap[rsp_tag_in]=1, SHALL clear the bit and add sign-extended rsp_credits_in to credits.
REQ-013 On an accept and a response in the same cycle, credits SHALL become credits-1+rsp_credits_in, and both bitmap updates SHALL apply; a same-tag response is applied before the issue check.
REQ-014 If the credit result is greater than the loaded room, SHALL set credit_overflow_error_out (sticky) and saturate credits at room.
REQ-015 If the credit result is negative, SHALL set credit_overflow_error_out (sticky) and clamp credits to 0.
REQ-016 On rsp_valid_in with bitmap[rsp_tag_in]=0, SHALL set tag_error_out[0] (sticky), leave credits unchanged and leave the bitmap unchanged.
REQ-017 On cmd_valid_in with bitmap[cmd_tag_in]=1 in ACTIVE, SHALL set tag_error_out[1] (sticky) and hold the command (not ready).
REQ-018 outstanding_out SHALL equal the bitmap population count and SHALL be maintained as an incremental counter (+1 issue, -1 valid response).
REQ-019 Responses SHALL still be processed in DRAINING and DISABLED.
REQ-020 Sticky errors SHALL clear only at reset or on session start.

Reset
REQ-021 On reset_in: state=DISABLED; credits=0; bitmap=0; outstanding_out=0; cmd_valid_out=0; cmd_tag_out=0; both errors=0; idle_out=1.
REQ-022 Reset asserted mid-operation SHALL abandon all in-flight tags, with no response checking for them afterwards.

Structure
REQ-023 The FSM state enum and the credit/tag typedefs SHALL live in AFU_PKG.
REQ-024 SHALL contain one sub-module, tag_bitmap, holding the set/clear/lookup array with two read ports.

Verification
REQ-025 Starvation: room_in=2, three back-to-back commands with tags 1,2,3 -> tags 1,2 issue on consecutive cycles, tag 3 stalls with credits=0; a response for tag 1 with credits=+1 -> tag 3 issues the next cycle.
REQ-026 Simultaneous events: credits=1, accept of tag 5 and response for tag 4 (+1) in the same cycle -> credits=1, outstanding unchanged.
REQ-027 Unknown tag: response for tag 9 while not outstanding -> tag_error_out=2'b01, credits unchanged.
REQ-028 Overflow: room_in=4, no commands, response for an issued tag with +2 -> credit_overflow_error_out=1, credits=4.
REQ-029 Drain: drop enabled_in with 3 tags outstanding -> DRAINING with cmd_ready_out=0; after 3 responses -> idle_out=1.
REQ-030 Reset mid-operation: assert reset_in with 5 tags outstanding -> all outputs at their reset values in the same cycle.

Source files
------------

// File: rtl/afu_pkg.sv
// Shared types for the PSL command credit tracker.
package afu_pkg;

    // Default widths; the tracker itself is parameterised.
    localparam int unsigned DefaultTagWidth    = 8;
    localparam int unsigned DefaultCreditWidth = 8;
    // Width of the signed credit return carried by a response.
    localparam int unsigned RspCreditWidth     = 9;

    typedef enum logic [1:0] {
        StDisabled,
        StActive,
        StDraining
    } state_e;

    typedef logic [DefaultTagWidth-1:0]       tag_t;
    typedef logic [DefaultCreditWidth-1:0]    credit_t;
    typedef logic signed [RspCreditWidth-1:0] rsp_credit_t;

endpackage

// File: rtl/tag_bitmap.sv
// One bit per command tag: set on issue, cleared on response, flushed at session start.
module tag_bitmap #(
    parameter int unsigned TAG_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 set_en_i,
    input  logic [TAG_WIDTH-1:0] set_idx_i,
    input  logic                 clr_en_i,
    input  logic [TAG_WIDTH-1:0] clr_idx_i,
    input  logic [TAG_WIDTH-1:0] rd_a_idx_i,
    output logic                 rd_a_o,
    input  logic [TAG_WIDTH-1:0] rd_b_idx_i,
    output logic                 rd_b_o
);

    localparam int unsigned Depth = 1 << TAG_WIDTH;

    logic [Depth-1:0] bits_q, bits_d;

    // Set wins over clear so a same-tag response plus reissue leaves the tag in flight.
    always_comb begin
        bits_d = bits_q;
        if (flush_i) begin
            bits_d = '0;
        end else begin
            if (clr_en_i) bits_d[clr_idx_i] = 1'b0;
            if (set_en_i) bits_d[set_idx_i] = 1'b1;
        end
    end

    // Bitmap state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bits_q <= '0;
        end else begin
            bits_q <= bits_d;
        end
    end

    assign rd_a_o = bits_q[rd_a_idx_i];
    assign rd_b_o = bits_q[rd_b_idx_i];

endmodule

// File: rtl/command_credit_tracker.sv
// Gates upstream commands on PSL credits and unique tags; tracks in-flight tags.
module command_credit_tracker
    import afu_pkg::*;
#(
    parameter int unsigned TAG_WIDTH    = 8,
    parameter int unsigned CREDIT_WIDTH = 8
) (
    input  logic                      clock,
    input  logic                      reset_in,
    input  logic                      enabled_in,
    input  logic [CREDIT_WIDTH-1:0]   room_in,
    input  logic                      cmd_valid_in,
    input  logic [TAG_WIDTH-1:0]      cmd_tag_in,
    output logic                      cmd_ready_out,
    output logic                      cmd_valid_out,
    output logic [TAG_WIDTH-1:0]      cmd_tag_out,
    input  logic                      rsp_valid_in,
    input  logic [TAG_WIDTH-1:0]      rsp_tag_in,
    input  logic [RspCreditWidth-1:0] rsp_credits_in,
    output logic [CREDIT_WIDTH-1:0]   credits_out,
    output logic [TAG_WIDTH:0]        outstanding_out,
    output logic                      idle_out,
    output logic                      credit_overflow_error_out,
    output logic [1:0]                tag_error_out
);

    // Two guard bits so credits - 1 + rsp can never wrap.
    localparam int unsigned SumW =
        ((CREDIT_WIDTH > RspCreditWidth) ? CREDIT_WIDTH : RspCreditWidth) + 2;

    state_e                  state_q, state_d;
    logic                    enabled_q;
    logic [CREDIT_WIDTH-1:0] credits_q, credits_d;
    logic [CREDIT_WIDTH-1:0] room_q, room_d;
    logic [TAG_WIDTH:0]      outstanding_q, outstanding_d;
    logic                    cmd_valid_q;
    logic [TAG_WIDTH-1:0]    cmd_tag_q;
    logic                    ovf_q, ovf_d;
    logic [1:0]              tag_err_q, tag_err_d;

    logic                    session_start;
    logic                    cmd_busy, rsp_busy;
    logic                    rsp_hit, cmd_blocked, accept;
    logic signed [SumW-1:0]  credit_ext, rsp_ext, room_ext, credit_sum;

    assign session_start = (state_q == StDisabled) && enabled_in && !enabled_q;

    // Responses in the session-start cycle are dropped along with the old bitmap.
    assign rsp_hit       = rsp_valid_in && rsp_busy && !session_start;
    // A same-tag response frees the tag before the issue check looks at it.
    assign cmd_blocked   = cmd_busy && !(rsp_hit && (rsp_tag_in == cmd_tag_in));
    assign cmd_ready_out = (state_q == StActive) && (credits_q != '0) && !cmd_blocked;
    assign accept        = cmd_valid_in && cmd_ready_out;

    tag_bitmap #(
        .TAG_WIDTH (TAG_WIDTH)
    ) u_tag_bitmap (
        .clk_i      (clock),
        .rst_i      (reset_in),
        .flush_i    (session_start),
        .set_en_i   (accept),
        .set_idx_i  (cmd_tag_in),
        .clr_en_i   (rsp_hit),
        .clr_idx_i  (rsp_tag_in),
        .rd_a_idx_i (cmd_tag_in),
        .rd_a_o     (cmd_busy),
        .rd_b_idx_i (rsp_tag_in),
        .rd_b_o     (rsp_busy)
    );

    // Session FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StDisabled: if (session_start) state_d = StActive;
            StActive:   if (!enabled_in) state_d = StDraining;
            StDraining: if (outstanding_q == '0) state_d = StDisabled;
            default:    state_d = StDisabled;
        endcase
    end

    // Signed credit arithmetic with clamp to [0, room].
    always_comb begin
        credit_ext = $signed({{(SumW-CREDIT_WIDTH){1'b0}}, credits_q});
        room_ext   = $signed({{(SumW-CREDIT_WIDTH){1'b0}}, room_q});
        rsp_ext    = $signed({{(SumW-RspCreditWidth){rsp_credits_in[RspCreditWidth-1]}},
                              rsp_credits_in});
        credit_sum = credit_ext;
        if (accept)  credit_sum = credit_sum - {{(SumW-1){1'b0}}, 1'b1};
        if (rsp_hit) credit_sum = credit_sum + rsp_ext;

        room_d    = room_q;
        credits_d = credits_q;
        ovf_d     = ovf_q;
        if (session_start) begin
            room_d    = room_in;
            credits_d = room_in;
            ovf_d     = 1'b0;
        end else if (credit_sum < 0) begin
            credits_d = '0;
            ovf_d     = 1'b1;
        end else if (credit_sum > room_ext) begin
            credits_d = room_q;
            ovf_d     = 1'b1;
        end else begin
            credits_d = credit_sum[CREDIT_WIDTH-1:0];
        end
    end

    // In-flight count and sticky tag errors.
    always_comb begin
        outstanding_d = outstanding_q;
        tag_err_d     = tag_err_q;
        if (session_start) begin
            outstanding_d = '0;
            tag_err_d     = 2'b00;
        end else begin
            if (accept && !rsp_hit) outstanding_d = outstanding_q + 1'b1;
            if (!accept && rsp_hit) outstanding_d = outstanding_q - 1'b1;
            if (rsp_valid_in && !rsp_busy) tag_err_d[0] = 1'b1;
            if ((state_q == StActive) && cmd_valid_in && cmd_blocked) tag_err_d[1] = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clock or posedge reset_in) begin
        if (reset_in) begin
            state_q       <= StDisabled;
            enabled_q     <= 1'b0;
            credits_q     <= '0;
            room_q        <= '0;
            outstanding_q <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_tag_q     <= '0;
            ovf_q         <= 1'b0;
            tag_err_q     <= 2'b00;
        end else begin
            state_q       <= state_d;
            enabled_q     <= enabled_in;
            credits_q     <= credits_d;
            room_q        <= room_d;
            outstanding_q <= outstanding_d;
            cmd_valid_q   <= accept;
            if (accept) cmd_tag_q <= cmd_tag_in;
            ovf_q         <= ovf_d;
            tag_err_q     <= tag_err_d;
        end
    end

    assign cmd_valid_out             = cmd_valid_q;
    assign cmd_tag_out               = cmd_tag_q;
    assign credits_out               = credits_q;
    assign outstanding_out           = outstanding_q;
    assign idle_out                  = (state_q == StDisabled);
    assign credit_overflow_error_out = ovf_q;
    assign tag_error_out             = tag_err_q;

endmodule

// File: tb/tb_command_credit_tracker.sv
// Directed bench for command_credit_tracker.
module tb_command_credit_tracker;

    logic       clock = 1'b0;
    logic       reset_in;
    logic       enabled_in;
    logic [7:0] room_in;
    logic       cmd_valid_in;
    logic [7:0] cmd_tag_in;
    logic       cmd_ready_out;
    logic       cmd_valid_out;
    logic [7:0] cmd_tag_out;
    logic       rsp_valid_in;
    logic [7:0] rsp_tag_in;
    logic [8:0] rsp_credits_in;
    logic [7:0] credits_out;
    logic [8:0] outstanding_out;
    logic       idle_out;
    logic       credit_overflow_error_out;
    logic [1:0] tag_error_out;

    int pass_cnt = 0;
    int total    = 0;

    command_credit_tracker #(
        .TAG_WIDTH    (8),
        .CREDIT_WIDTH (8)
    ) dut (
        .clock                     (clock),
        .reset_in                  (reset_in),
        .enabled_in                (enabled_in),
        .room_in                   (room_in),
        .cmd_valid_in              (cmd_valid_in),
        .cmd_tag_in                (cmd_tag_in),
        .cmd_ready_out             (cmd_ready_out),
        .cmd_valid_out             (cmd_valid_out),
        .cmd_tag_out               (cmd_tag_out),
        .rsp_valid_in              (rsp_valid_in),
        .rsp_tag_in                (rsp_tag_in),
        .rsp_credits_in            (rsp_credits_in),
        .credits_out               (credits_out),
        .outstanding_out           (outstanding_out),
        .idle_out                  (idle_out),
        .credit_overflow_error_out (credit_overflow_error_out),
        .tag_error_out             (tag_error_out)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cmd(input logic v, input logic [7:0] t);
        cmd_valid_in = v;
        cmd_tag_in   = t;
    endtask

    task automatic rsp(input logic v, input logic [7:0] t, input logic [8:0] c);
        rsp_valid_in   = v;
        rsp_tag_in     = t;
        rsp_credits_in = c;
    endtask

    initial begin
        reset_in   = 1'b1;
        enabled_in = 1'b0;
        room_in    = 8'd0;
        cmd(1'b0, 8'd0);
        rsp(1'b0, 8'd0, 9'd0);
        #1;
        chk("rst_idle", idle_out, 1);
        chk("rst_credits", credits_out, 0);
        chk("rst_outstanding", outstanding_out, 0);
        chk("rst_cmd_valid", cmd_valid_out, 0);
        chk("rst_errors", {credit_overflow_error_out, tag_error_out}, 0);
        step();
        step();
        reset_in = 1'b0;
        step();

        // Starvation: room 2, tags 1,2,3
        room_in    = 8'd2;
        enabled_in = 1'b1;
        step();
        chk("s1_credits_loaded", credits_out, 2);
        chk("s1_active", idle_out, 0);
        cmd(1'b1, 8'd1);
        #1 chk("s1_ready_t1", cmd_ready_out, 1);
        step();
        chk("s1_issue_t1", {cmd_valid_out, cmd_tag_out}, {1'b1, 8'd1});
        chk("s1_credits_1", credits_out, 1);
        cmd(1'b1, 8'd2);
        step();
        chk("s1_issue_t2", {cmd_valid_out, cmd_tag_out}, {1'b1, 8'd2});
        chk("s1_credits_0", credits_out, 0);
        cmd(1'b1, 8'd3);
        #1 chk("s1_t3_stall", cmd_ready_out, 0);
        step();
        chk("s1_no_issue", cmd_valid_out, 0);
        chk("s1_outstanding_2", outstanding_out, 2);
        rsp(1'b1, 8'd1, 9'd1);
        step();
        chk("s1_rsp_credit", credits_out, 1);
        chk("s1_rsp_outstanding", outstanding_out, 1);
        rsp(1'b0, 8'd0, 9'd0);
        step();
        chk("s1_issue_t3", {cmd_valid_out, cmd_tag_out}, {1'b1, 8'd3});
        chk("s1_credits_after_t3", credits_out, 0);
        cmd(1'b0, 8'd0);

        // Build credits=1 with tags 3,4 outstanding
        rsp(1'b1, 8'd2, 9'd2);
        step();
        rsp(1'b0, 8'd0, 9'd0);
        cmd(1'b1, 8'd4);
        step();
        chk("s2_pre_credits", credits_out, 1);
        chk("s2_pre_outstanding", outstanding_out, 2);

        // Simultaneous accept tag5 + response tag4 (+1)
        cmd(1'b1, 8'd5);
        rsp(1'b1, 8'd4, 9'd1);
        step();
        chk("s2_sim_issue", {cmd_valid_out, cmd_tag_out}, {1'b1, 8'd5});
        chk("s2_sim_credits", credits_out, 1);
        chk("s2_sim_outstanding", outstanding_out, 2);

        // Unknown response tag 9
        cmd(1'b0, 8'd0);
        rsp(1'b1, 8'd9, 9'd1);
        step();
        chk("s3_unknown_tag", tag_error_out, 2'b01);
        chk("s3_credits_kept", credits_out, 1);
        chk("s3_outstanding_kept", outstanding_out, 2);

        // Duplicate issue of tag 3
        rsp(1'b0, 8'd0, 9'd0);
        cmd(1'b1, 8'd3);
        #1 chk("s4_dup_not_ready", cmd_ready_out, 0);
        step();
        chk("s4_dup_error", tag_error_out, 2'b11);
        chk("s4_dup_no_issue", cmd_valid_out, 0);

        // Same-tag response and reissue of tag 5
        cmd(1'b1, 8'd5);
        rsp(1'b1, 8'd5, 9'd1);
        #1 chk("s5_same_tag_ready", cmd_ready_out, 1);
        step();
        chk("s5_same_tag_issue", {cmd_valid_out, cmd_tag_out}, {1'b1, 8'd5});
        chk("s5_same_tag_credits", credits_out, 1);
        chk("s5_same_tag_outstanding", outstanding_out, 2);

        // Negative credit return clamps to 0
        cmd(1'b0, 8'd0);
        rsp(1'b1, 8'd3, 9'h1FD);
        step();
        chk("s6_neg_clamp", credits_out, 0);
        chk("s6_neg_ovf", credit_overflow_error_out, 1);
        chk("s6_outstanding", outstanding_out, 1);

        // Close the first session
        rsp(1'b1, 8'd5, 9'd0);
        step();
        rsp(1'b0, 8'd0, 9'd0);
        enabled_in = 1'b0;
        step();
        chk("s7_draining", idle_out, 0);
        step();
        chk("s7_idle", idle_out, 1);

        // New session room 4 clears sticky errors
        room_in    = 8'd4;
        enabled_in = 1'b1;
        step();
        chk("s8_credits_loaded", credits_out, 4);
        chk("s8_errors_cleared", {credit_overflow_error_out, tag_error_out}, 0);
        cmd(1'b1, 8'd7);
        step();
        cmd(1'b0, 8'd0);
        rsp(1'b1, 8'd7, 9'd2);
        step();
        chk("s8_ovf_flag", credit_overflow_error_out, 1);
        chk("s8_ovf_saturate", credits_out, 4);
        rsp(1'b0, 8'd0, 9'd0);

        // Drain with 3 outstanding
        cmd(1'b1, 8'd20);
        step();
        cmd(1'b1, 8'd21);
        step();
        cmd(1'b1, 8'd22);
        step();
        chk("s9_outstanding_3", outstanding_out, 3);
        chk("s9_credits_1", credits_out, 1);
        cmd(1'b0, 8'd0);
        enabled_in = 1'b0;
        step();
        cmd(1'b1, 8'd30);
        #1 chk("s9_drain_not_ready", cmd_ready_out, 0);
        chk("s9_drain_not_idle", idle_out, 0);
        rsp(1'b1, 8'd20, 9'd1);
        step();
        rsp(1'b1, 8'd21, 9'd1);
        step();
        rsp(1'b1, 8'd22, 9'd1);
        step();
        rsp(1'b0, 8'd0, 9'd0);
        chk("s9_drain_credits", credits_out, 4);
        chk("s9_drain_no_issue", cmd_valid_out, 0);
        step();
        chk("s9_drain_idle", idle_out, 1);

        // Response while disabled is still checked
        cmd(1'b0, 8'd0);
        rsp(1'b1, 8'd40, 9'd1);
        step();
        chk("s10_disabled_unknown", tag_error_out, 2'b01);
        rsp(1'b0, 8'd0, 9'd0);

        // Reset mid-operation with 5 outstanding
        room_in    = 8'd8;
        enabled_in = 1'b1;
        step();
        for (int i = 1; i <= 5; i++) begin
            cmd(1'b1, 8'(i));
            step();
        end
        chk("s11_outstanding_5", outstanding_out, 5);
        chk("s11_credits_3", credits_out, 3);
        reset_in = 1'b1;
        #1;
        chk("s11_rst_idle", idle_out, 1);
        chk("s11_rst_credits", credits_out, 0);
        chk("s11_rst_outstanding", outstanding_out, 0);
        chk("s11_rst_cmd", {cmd_valid_out, cmd_tag_out}, 0);
        chk("s11_rst_errors", {credit_overflow_error_out, tag_error_out}, 0);
        chk("s11_rst_ready", cmd_ready_out, 0);
        cmd(1'b0, 8'd0);
        enabled_in = 1'b0;
        step();
        reset_in = 1'b0;
        step();
        rsp(1'b1, 8'd1, 9'd1);
        step();
        chk("s11_abandoned_tag", tag_error_out, 2'b01);
        chk("s11_abandoned_credits", credits_out, 0);
        rsp(1'b0, 8'd0, 9'd0);
        step();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
